muldiv_unit: RTL and testbench

- Iterative RV64M/RV32M multiply/divide execution unit in the EX stage.
- Consumes the two register-file read operands (after forwarding) and produces one XLEN-wide result plus its destination index for writeback into the register file.
- Holds the pipeline via `o_busy` while iterating, one bit per cycle.
- Gated by the same global clock enable as the rest of the datapath.

---
 rtl/muldiv_unit_pkg.sv | 36 +++
 rtl/muldiv_unit_div_step.sv | 28 ++
 rtl/muldiv_unit.sv | 197 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: XLEN codes,
// M-extension funct3 values, FSM state codes and operand-signedness decode.
package muldiv_unit_pkg;

  localparam logic [1:0] XLEN_32B = 2'd1;
  localparam logic [1:0] XLEN_64B = 2'd2;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic rs1_signed(input logic [2:0] f3);
    case (f3)
      F3_MULH, F3_MULHSU, F3_DIV, F3_REM: rs1_signed = 1'b1;
      default:                            rs1_signed = 1'b0;
    endcase
  endfunction

  function automatic logic rs2_signed(input logic [2:0] f3);
    case (f3)
      F3_MULH, F3_DIV, F3_REM: rs2_signed = 1'b1;
      default:                 rs2_signed = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division step: shift in the next dividend bit and subtract
// the divisor when it fits, producing one quotient bit.
module muldiv_unit_div_step #(
  parameter int W = 64
) (
  input  logic [W-1:0] rem_in,
  input  logic         dividend_bit,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0] shifted_s;
  logic [W:0] diff_s;

  // A clear borrow bit means the divisor fitted into the shifted remainder
  always_comb begin
    shifted_s = {rem_in, dividend_bit};
    diff_s    = shifted_s - {1'b0, divisor};
    q_bit     = ~diff_s[W];
    if (q_bit) begin
      rem_out = diff_s[W-1:0];
    end else begin
      rem_out = shifted_s[W-1:0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64M/RV32M multiply/divide unit: shift-add multiply and restoring
// divide, one bit per enabled cycle, with divide-by-zero/overflow fast paths.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter  logic [1:0] XLEN = XLEN_64B,
  localparam int         W    = 1 << (XLEN + 4)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clk_enable,
  input  logic         i_start,
  input  logic [2:0]   i_funct3,
  input  logic         i_word,
  input  logic [W-1:0] i_rs1,
  input  logic [W-1:0] i_rs2,
  input  logic [4:0]   i_rd_addr,
  input  logic         i_flush,
  output logic         o_busy,
  output logic         o_valid,
  output logic [W-1:0] o_result,
  output logic [4:0]   o_rd_addr
);

  localparam int           CW   = $clog2(W) + 1;
  localparam logic [W-1:0] LO32 = W'(32'hFFFF_FFFF);

  logic [1:0]     state_r;
  logic [CW-1:0]  cnt_r;
  logic [2:0]     funct3_r;
  logic           word_r, res_neg_r, rem_neg_r, valid_r, busy_r;
  logic [4:0]     rd_r;
  logic [2*W-1:0] acc_r, mcand_r;
  logic [W-1:0]   mplier_r, rem_r, quo_r, dvsr_r, result_r;

  logic           word_eff_s, a_neg_s, b_neg_s, div_zero_s, ovf_s, fast_s, last_s, qbit_s;
  logic [W-1:0]   mask_s, a_raw_s, b_raw_s, a_mag_s, b_mag_s, most_neg_s, fast_res_s;
  logic [W-1:0]   rmask_s, rem_nxt_s, quo_nxt_s, q_s, r_s, mul_res_s, div_res_s;
  logic [2*W-1:0] acc_nxt_s, prod_s;

  // Word results are sign-extended from bit 31, unsigned divides included
  function automatic logic [W-1:0] fit_word(input logic [W-1:0] x, input logic w);
    if (!w) begin
      fit_word = x;
    end else if (x[31]) begin
      fit_word = x | ~LO32;
    end else begin
      fit_word = x & LO32;
    end
  endfunction

  muldiv_unit_div_step #(.W(W)) u_div_step (
    .rem_in       (rem_r),
    .dividend_bit (quo_r[W-1]),
    .divisor      (dvsr_r),
    .rem_out      (rem_nxt_s),
    .q_bit        (qbit_s)
  );

  // Operand preparation and fast-path detection from the live request
  always_comb begin
    word_eff_s = i_word & (W == 64);
    mask_s     = word_eff_s ? LO32 : '1;
    a_raw_s    = i_rs1 & mask_s;
    b_raw_s    = i_rs2 & mask_s;
    a_neg_s    = rs1_signed(i_funct3) & (word_eff_s ? i_rs1[31] : i_rs1[W-1]);
    b_neg_s    = rs2_signed(i_funct3) & (word_eff_s ? i_rs2[31] : i_rs2[W-1]);
    a_mag_s    = a_neg_s ? ((-a_raw_s) & mask_s) : a_raw_s;
    b_mag_s    = b_neg_s ? ((-b_raw_s) & mask_s) : b_raw_s;
    most_neg_s = word_eff_s ? W'(32'h8000_0000) : {1'b1, {(W-1){1'b0}}};
    div_zero_s = (b_raw_s == '0);
    ovf_s      = rs2_signed(i_funct3) & (a_raw_s == most_neg_s) & (b_raw_s == mask_s);
    fast_s     = i_funct3[2] & (div_zero_s | ovf_s);
    if (i_funct3[1]) begin
      fast_res_s = div_zero_s ? a_raw_s : '0;
    end else begin
      fast_res_s = div_zero_s ? '1 : a_raw_s;
    end
    fast_res_s = fit_word(fast_res_s, word_eff_s);
  end

  // Next iteration values; the final result is formed from the last step directly
  always_comb begin
    rmask_s   = word_r ? LO32 : '1;
    last_s    = (cnt_r == CW'(1));
    acc_nxt_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
    prod_s    = res_neg_r ? -acc_nxt_s : acc_nxt_s;
    if (funct3_r == F3_MUL) begin
      mul_res_s = prod_s[W-1:0];
    end else if (word_r) begin
      mul_res_s = W'(prod_s[63:32]);
    end else begin
      mul_res_s = prod_s[2*W-1:W];
    end
    mul_res_s = fit_word(mul_res_s, word_r);
    quo_nxt_s = {quo_r[W-2:0], qbit_s};
    q_s       = quo_nxt_s & rmask_s;
    q_s       = res_neg_r ? -q_s : q_s;
    r_s       = rem_neg_r ? -rem_nxt_s : rem_nxt_s;
    div_res_s = fit_word(funct3_r[1] ? r_s : q_s, word_r);
  end

  // FSM, counter and datapath registers; everything freezes while the enable is low
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      funct3_r  <= 3'b000;
      word_r    <= 1'b0;
      res_neg_r <= 1'b0;
      rem_neg_r <= 1'b0;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      rd_r      <= 5'd0;
      acc_r     <= '0;
      mcand_r   <= '0;
      mplier_r  <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
      dvsr_r    <= '0;
      result_r  <= '0;
    end else if (i_clk_enable) begin
      if (i_flush) begin
        state_r <= ST_IDLE;
        valid_r <= 1'b0;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE, ST_DONE: begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            if (i_start) begin
              funct3_r  <= i_funct3;
              word_r    <= word_eff_s;
              rd_r      <= i_rd_addr;
              res_neg_r <= a_neg_s ^ b_neg_s;
              rem_neg_r <= a_neg_s;
              cnt_r     <= word_eff_s ? CW'(32) : CW'(W);
              acc_r     <= '0;
              mcand_r   <= (2*W)'(a_mag_s);
              mplier_r  <= b_mag_s;
              rem_r     <= '0;
              quo_r     <= word_eff_s ? (a_mag_s << (W - 32)) : a_mag_s;
              dvsr_r    <= b_mag_s;
              if (fast_s) begin
                state_r  <= ST_DONE;
                valid_r  <= 1'b1;
                result_r <= fast_res_s;
              end else if (i_funct3[2]) begin
                state_r <= ST_DIV;
                busy_r  <= 1'b1;
              end else begin
                state_r <= ST_MUL;
                busy_r  <= 1'b1;
              end
            end
          end
          ST_MUL: begin
            acc_r    <= acc_nxt_s;
            mcand_r  <= {mcand_r[2*W-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[W-1:1]};
            cnt_r    <= cnt_r - CW'(1);
            if (last_s) begin
              state_r  <= ST_DONE;
              busy_r   <= 1'b0;
              valid_r  <= 1'b1;
              result_r <= mul_res_s;
            end
          end
          ST_DIV: begin
            rem_r <= rem_nxt_s;
            quo_r <= quo_nxt_s;
            cnt_r <= cnt_r - CW'(1);
            if (last_s) begin
              state_r  <= ST_DONE;
              busy_r   <= 1'b0;
              valid_r  <= 1'b1;
              result_r <= div_res_s;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_busy    = busy_r;
  assign o_valid   = valid_r;
  assign o_result  = result_r;
  assign o_rd_addr = rd_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (W=64): directed vectors push expected
// result/rd/latency; a negedge monitor pops and compares on each o_valid.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam logic [63:0] ALL1   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINUS7 = 64'hFFFF_FFFF_FFFF_FFF9;
  localparam logic [63:0] MINUS3 = 64'hFFFF_FFFF_FFFF_FFFD;
  localparam logic [63:0] MNEG   = 64'h8000_0000_0000_0000;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    int          acc;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, en, start, word, flush;
  logic [2:0]  funct3;
  logic [63:0] rs1, rs2;
  logic [4:0]  rd_addr;
  logic        busy, valid;
  logic [63:0] result;
  logic [4:0]  rd_out;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  muldiv_unit #(.XLEN(XLEN_64B)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_clk_enable (en),
    .i_start      (start),
    .i_funct3     (funct3),
    .i_word       (word),
    .i_rs1        (rs1),
    .i_rs2        (rs2),
    .i_rd_addr    (rd_addr),
    .i_flush      (flush),
    .o_busy       (busy),
    .o_valid      (valid),
    .o_result     (result),
    .o_rd_addr    (rd_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns just after the accept edge
  task automatic issue(input logic [2:0] f3, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd,
                       input logic [63:0] exp_res, input int lat, input bit track);
    exp_t e;
    start = 1'b1; funct3 = f3; word = w; rs1 = a; rs2 = b; rd_addr = rd;
    @(posedge clk);
    #1;
    e.res = exp_res; e.rd = rd; e.acc = cyc; e.lat = lat;
    if (track) sb_q.push_back(e);
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    @(negedge clk);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("valid_timeout", 64'(valid), 64'd1);
  endtask

  // Scoreboard monitor: busy run length and latency are checked alongside the result
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) begin
        busy_cnt++;
      end else begin
        if (valid) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid result=%h rd=%0d", result, rd_out);
          end else begin
            mon_e = sb_q.pop_front();
            check("result", result, mon_e.res);
            check("rd_addr", 64'(rd_out), 64'(mon_e.rd));
            check("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
            check("busy_cycles", 64'(busy_cnt), 64'(mon_e.lat));
          end
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0; word = 1'b0; flush = 1'b0;
    funct3 = 3'b000; rs1 = 64'd0; rs2 = 64'd0; rd_addr = 5'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_valid", 64'(valid), 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_rd", 64'(rd_out), 64'd0);

    issue(F3_MUL,    1'b0, 64'd7, MINUS3, 5'd1, 64'hFFFF_FFFF_FFFF_FFEB, 64, 1'b1); drain();
    issue(F3_MULHU,  1'b0, ALL1,  ALL1,   5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64, 1'b1); drain();
    issue(F3_MULHSU, 1'b0, ALL1,  64'd2,  5'd3, ALL1,                    64, 1'b1); drain();
    issue(F3_DIV,    1'b0, MINUS7, 64'd2, 5'd4, MINUS3,                  64, 1'b1); drain();
    issue(F3_REM,    1'b0, MINUS7, 64'd2, 5'd5, ALL1,                    64, 1'b1); drain();
    issue(F3_DIVU,   1'b1, 64'h1_8000_0000, 64'd1, 5'd6, 64'hFFFF_FFFF_8000_0000, 32, 1'b1); drain();
    issue(F3_MUL,    1'b1, 64'h1_0000_0003, 64'd5, 5'd7, 64'd15,         32, 1'b1); drain();
    issue(F3_DIV,    1'b0, 64'd5, 64'd0,  5'd8,  ALL1,                   0, 1'b1); drain();
    issue(F3_REMU,   1'b0, 64'd5, 64'd0,  5'd9,  64'd5,                  0, 1'b1); drain();
    issue(F3_DIV,    1'b0, MNEG,  ALL1,   5'd10, MNEG,                   0, 1'b1); drain();
    issue(F3_REM,    1'b0, MNEG,  ALL1,   5'd11, 64'd0,                  0, 1'b1); drain();

    // Back-to-back: second start lands in the DONE cycle of the first
    issue(F3_DIV,    1'b1, MINUS7, 64'd2, 5'd12, MINUS3, 32, 1'b1);
    wait_valid();
    issue(F3_REMU,   1'b0, 64'd100, 64'd7, 5'd13, 64'd2, 64, 1'b1);
    drain();

    // Flush at the tenth iteration edge: no valid, result held at 2
    issue(F3_MUL, 1'b0, 64'd7, MINUS3, 5'd20, 64'd0, 64, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    check("flush_result", result, 64'd2);
    check("flush_busy", 64'(busy), 64'd0);
    issue(F3_DIVU, 1'b0, 64'd100, 64'd7, 5'd21, 64'd14, 64, 1'b1);
    drain();

    // Clock enable low for 5 edges mid-DIV stretches latency by 5
    issue(F3_DIV, 1'b0, MINUS7, 64'd2, 5'd22, MINUS3, 69, 1'b1);
    repeat (20) @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    en = 1'b1;
    drain();

    // Synchronous reset mid-MUL clears every output
    issue(F3_MUL, 1'b0, 64'd7, MINUS3, 5'd31, 64'd0, 64, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_valid", 64'(valid), 64'd0);
    check("rst_mid_result", result, 64'd0);
    check("rst_mid_rd", 64'(rd_out), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    issue(F3_MUL, 1'b0, 64'd7, MINUS3, 5'd1, 64'hFFFF_FFFF_FFFF_FFEB, 64, 1'b1); drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
